// File: rtl/alu_control_md.sv
// ALU control with funct decode, optional output register,
// mult/div sequencer and HI/LO read-after-write interlock.
module alu_control_md #(
  parameter int OP_W      = 4,
  parameter int MD_CYCLES = 32,
  parameter int PIPE      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [1:0]      Alu_op,
  input  logic [5:0]      functionfield,
  input  logic            flush,
  output logic [OP_W-1:0] operacion,
  output logic            illegal,
  output logic            md_start,
  output logic [1:0]      md_kind,
  output logic            md_busy,
  output logic            hilo_we,
  output logic            stall
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_start;
  logic            r_busy;
  logic            r_hilo;
  logic [1:0]      r_kind;

  logic [3:0]      w_code;
  logic            w_ill;
  logic            w_rtype;
  logic            w_is_md;
  logic            w_is_mfx;
  logic            w_accept;
  logic [OP_W-1:0] w_op;

  assign w_rtype  = (Alu_op == 2'b10);
  assign w_is_md  = (functionfield[5:2] == 4'b0110);
  assign w_is_mfx = (functionfield == 6'b010000) ||
                    (functionfield == 6'b010010);

  // HI/LO consumers and new mult/div wait while the unit is busy
  assign stall = valid && r_busy && w_rtype &&
                 (w_is_md || w_is_mfx);

  assign w_accept = valid && w_rtype && w_is_md &&
                    !flush && (r_state == S_IDLE);

  always_comb begin
    w_code = 4'b0010;
    w_ill  = 1'b0;
    unique case (Alu_op)
      2'b00: w_code = 4'b0010;
      2'b01: w_code = 4'b0110;
      2'b11: w_code = 4'b0001;
      2'b10: begin
        case (functionfield)
          6'b100000,
          6'b100001: w_code = 4'b0010;
          6'b100010,
          6'b100011: w_code = 4'b0110;
          6'b100100: w_code = 4'b0000;
          6'b100101: w_code = 4'b0001;
          6'b100110: w_code = 4'b0011;
          6'b100111: w_code = 4'b1100;
          6'b101010: w_code = 4'b0111;
          6'b101011: w_code = 4'b1000;
          6'b010000: w_code = 4'b1101;
          6'b010010: w_code = 4'b1110;
          6'b011000,
          6'b011001,
          6'b011010,
          6'b011011: w_code = 4'b0010;
          default: begin
            w_code = 4'b0010;
            w_ill  = 1'b1;
          end
        endcase
      end
      default: w_code = 4'b0010;
    endcase
  end

  assign w_op = OP_W'(w_code);

  generate
    if (PIPE != 0) begin : g_pipe
      logic [OP_W-1:0] r_op;
      logic            r_ill;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_op  <= '0;
          r_ill <= 1'b0;
        end else if (valid && !stall) begin
          r_op  <= w_op;
          r_ill <= w_ill;
        end
      end

      assign operacion = r_op;
      assign illegal   = r_ill;
    end else begin : g_comb
      assign operacion = w_op;
      assign illegal   = w_ill;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_hilo  <= 1'b0;
      r_kind  <= 2'b00;
    end else begin
      r_start <= 1'b0;
      r_hilo  <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state <= S_RUN;
              r_cnt   <= CW'(MD_CYCLES - 1);
              r_kind  <= {functionfield[1], functionfield[0]};
              r_start <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          S_RUN: begin
            if (r_cnt == '0) begin
              r_state <= S_DONE;
              r_hilo  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign md_start = r_start;
  assign md_busy  = r_busy;
  assign hilo_we  = r_hilo;
  assign md_kind  = r_kind;

endmodule
